// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  localparam int DMEM_ADDR_W = 4;
  localparam int DMEM_DATA_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's command/response bundle toward the data-memory arbiter.
// Handshake: the master holds req/we/lock/addr/wdata stable until it samples gnt=1;
// the transfer happens in that cycle, and a read returns rdata with a 1-cycle rvalid pulse in the next cycle.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arb_rsp.sv
// Read-return register for one arbiter port: captures memory data on a read grant
// and pulses rvalid the following cycle; rdata holds until the next read.
module dmem_arb_rsp #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_i) rdata_d = mem_rdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_i;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the debug/DMA requester.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise fixed CPU priority with dbg starvation override.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dbg,
  output logic              mem_e_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output owner_t            owner_o
);

  owner_t owner_q, owner_d;
  logic   gnt_cpu, gnt_dbg;
  logic   dbg_force;  // dbg wins even against an OWN_CPU lock
  logic   dbg_pref;   // dbg wins an IDLE contention

`ifdef DMEM_ARB_RR_EN
  logic last_win_q, last_win_d;

  assign dbg_force = 1'b0;
  assign dbg_pref  = (last_win_q == REQ_CPU);

  always_comb begin
    last_win_d = last_win_q;
    if (gnt_cpu) last_win_d = REQ_CPU;
    else if (gnt_dbg) last_win_d = REQ_DBG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_win_q <= REQ_DBG;
    else     last_win_q <= last_win_d;
  end
`else
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  assign dbg_force = dbg.req && (starve_cnt_q == STARVE_LIM);
  assign dbg_pref  = dbg_force;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!dbg.req || gnt_dbg)           starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + SCW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`endif

  // An owner that drops req releases ownership in the same cycle, so that cycle arbitrates as IDLE.
  always_comb begin
    gnt_cpu = 1'b0;
    gnt_dbg = 1'b0;
    if (!rst) begin
      if (owner_q == OWN_CPU && cpu.req) begin
        if (dbg_force) gnt_dbg = 1'b1;
        else           gnt_cpu = 1'b1;
      end else if (owner_q == OWN_DBG && dbg.req) begin
        gnt_dbg = 1'b1;
      end else if (cpu.req && dbg.req) begin
        if (dbg_pref) gnt_dbg = 1'b1;
        else          gnt_cpu = 1'b1;
      end else begin
        gnt_cpu = cpu.req;
        gnt_dbg = dbg.req;
      end
    end
  end

  always_comb begin
    owner_d = OWN_IDLE;
    if (gnt_cpu && cpu.lock)      owner_d = OWN_CPU;
    else if (gnt_dbg && dbg.lock) owner_d = OWN_DBG;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= OWN_IDLE;
    else     owner_q <= owner_d;
  end

  always_comb begin
    mem_e_o     = gnt_cpu | gnt_dbg;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt_cpu) begin
      mem_we_o    = cpu.we;
      mem_addr_o  = cpu.addr;
      mem_wdata_o = cpu.wdata;
    end else if (gnt_dbg) begin
      mem_we_o    = dbg.we;
      mem_addr_o  = dbg.addr;
      mem_wdata_o = dbg.wdata;
    end
  end

  assign cpu.gnt = gnt_cpu;
  assign dbg.gnt = gnt_dbg;
  assign owner_o = owner_q;

  dmem_arb_rsp #(.DATA_W(DATA_W)) u_rsp_cpu (
    .clk        (clk),
    .rst        (rst),
    .rd_i       (gnt_cpu & ~cpu.we),
    .mem_rdata_i(mem_rdata_i),
    .rvalid_o   (cpu.rvalid),
    .rdata_o    (cpu.rdata)
  );

  dmem_arb_rsp #(.DATA_W(DATA_W)) u_rsp_dbg (
    .clk        (clk),
    .rst        (rst),
    .rd_i       (gnt_dbg & ~dbg.we),
    .mem_rdata_i(mem_rdata_i),
    .rvalid_o   (dbg.rvalid),
    .rdata_o    (dbg.rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory behind it.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) cpu_if ();
  dmem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) dbg_if ();

  logic       mem_e, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  owner_t     owner;

  logic [7:0] mem [16];
  always @(posedge clk) if (mem_e && mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu        (cpu_if),
    .dbg        (dbg_if),
    .mem_e_o    (mem_e),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata),
    .owner_o    (owner)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_d;

  task automatic drive_cpu(input logic req, input logic we, input logic lock,
                           input logic [3:0] addr, input logic [7:0] wdata);
    cpu_if.req = req; cpu_if.we = we; cpu_if.lock = lock;
    cpu_if.addr = addr; cpu_if.wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic lock,
                           input logic [3:0] addr, input logic [7:0] wdata);
    dbg_if.req = req; dbg_if.we = we; dbg_if.lock = lock;
    dbg_if.addr = addr; dbg_if.wdata = wdata;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    drive_dbg(0, 0, 0, 4'd0, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_cpu(1, 1, 0, 4'd1, 8'h11);
    drive_dbg(1, 1, 0, 4'd2, 8'h22);
    @(negedge clk); @(negedge clk);
    n_checks++; if (cpu_if.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_if.gnt); end
    n_checks++; if (dbg_if.gnt !== 1'b0) begin n_fail++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_if.gnt); end
    n_checks++; if (mem_e !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_e: got e=%b we=%b want 0 0", mem_e, mem_we); end
    n_checks++; if (cpu_if.rvalid !== 1'b0 || dbg_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b %b want 0 0", cpu_if.rvalid, dbg_if.rvalid); end
    n_checks++; if (cpu_if.rdata !== 8'h00 || dbg_if.rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 00 00", cpu_if.rdata, dbg_if.rdata); end
    n_checks++; if (owner !== OWN_IDLE) begin n_fail++; $display("FAIL reset_owner: got %0d want %0d", owner, OWN_IDLE); end
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    drive_dbg(0, 0, 0, 4'd0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(posedge clk); #1;
    drive_cpu(1, 1, 0, 4'd3, 8'hA5);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    n_checks++; if (cpu_if.gnt !== 1'b1 || dbg_if.gnt !== 1'b0) begin n_fail++; $display("FAIL wr_gnt: got cpu=%b dbg=%b want 1 0", cpu_if.gnt, dbg_if.gnt); end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_mem: got we=%b a=%h d=%h want 1 3 a5", mem_we, mem_addr, mem_wdata); end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    drive_dbg(1, 0, 0, 4'd3, 8'h00);
    @(negedge clk);
    n_checks++; if (dbg_if.gnt !== 1'b1 || mem_e !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_gnt: got gnt=%b e=%b we=%b want 1 1 0", dbg_if.gnt, mem_e, mem_we); end
    @(posedge clk); #1;
    drive_dbg(0, 0, 0, 4'd0, 8'h00);
    @(negedge clk);
    exp_d = exp_q.pop_front();
    n_checks++; if (dbg_if.rvalid !== 1'b1 || dbg_if.rdata !== exp_d) begin n_fail++; $display("FAIL rd_return: got v=%b d=%h want 1 %h", dbg_if.rvalid, dbg_if.rdata, exp_d); end
    n_checks++; if (cpu_if.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_cpu_quiet: got %b want 0", cpu_if.rvalid); end
    @(negedge clk);
    n_checks++; if (dbg_if.rvalid !== 1'b0 || dbg_if.rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_hold: got v=%b d=%h want 0 a5", dbg_if.rvalid, dbg_if.rdata); end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    drive_cpu(1, 0, 0, 4'd3, 8'h00);
    @(negedge clk);
    n_checks++; if (cpu_if.gnt !== 1'b1) begin n_fail++; $display("FAIL midrd_gnt: got %b want 1", cpu_if.gnt); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (cpu_if.gnt !== 1'b0 || mem_e !== 1'b0) begin n_fail++; $display("FAIL midrd_rst_gnt: got gnt=%b e=%b want 0 0", cpu_if.gnt, mem_e); end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    n_checks++; if (cpu_if.rvalid !== 1'b0 || owner !== OWN_IDLE) begin n_fail++; $display("FAIL midrd_drop: got v=%b own=%0d want 0 0", cpu_if.rvalid, owner); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_if.rvalid !== 1'b0 || cpu_if.rdata !== 8'h00) begin n_fail++; $display("FAIL midrd_after: got v=%b d=%h want 0 00", cpu_if.rvalid, cpu_if.rdata); end
    n_checks++; if (dbg_if.rdata !== 8'h00) begin n_fail++; $display("FAIL midrd_dbg_rdata: got %h want 00", dbg_if.rdata); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive_dbg(1, 1, 0, 4'd5, 8'h3C);
    @(negedge clk);
    n_checks++; if (dbg_if.gnt !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL b2b_dbg_wr: got gnt=%b we=%b want 1 1", dbg_if.gnt, mem_we); end
    @(posedge clk); #1;
    drive_dbg(0, 0, 0, 4'd0, 8'h00);
    drive_cpu(1, 0, 0, 4'd3, 8'h00);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    n_checks++; if (cpu_if.gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_rd1_gnt: got %b want 1", cpu_if.gnt); end
    @(posedge clk); #1;
    drive_cpu(1, 0, 0, 4'd5, 8'h00);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    exp_d = exp_q.pop_front();
    n_checks++; if (cpu_if.gnt !== 1'b1 || cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rd1_ret: got g=%b v=%b d=%h want 1 1 %h", cpu_if.gnt, cpu_if.rvalid, cpu_if.rdata, exp_d); end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    @(negedge clk);
    exp_d = exp_q.pop_front();
    n_checks++; if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rd2_ret: got v=%b d=%h want 1 %h", cpu_if.rvalid, cpu_if.rdata, exp_d); end
    @(negedge clk);
    n_checks++; if (cpu_if.rvalid !== 1'b0 || cpu_if.rdata !== 8'h3C) begin n_fail++; $display("FAIL b2b_hold: got v=%b d=%h want 0 3c", cpu_if.rvalid, cpu_if.rdata); end
  endtask

  task automatic test_contention();
    logic [9:0] dbg_pat;
`ifdef DMEM_ARB_RR_EN
    dbg_pat = 10'b1010101010;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
`else
    dbg_pat = 10'b1000010000;
`endif
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive_cpu(1, 0, 0, 4'd1, 8'h00);
      drive_dbg(1, 0, 0, 4'd2, 8'h00);
      @(negedge clk);
      n_checks++;
      if (cpu_if.gnt !== ~dbg_pat[i] || dbg_if.gnt !== dbg_pat[i] || mem_e !== 1'b1) begin
        n_fail++;
        $display("FAIL contention[%0d]: got cpu=%b dbg=%b e=%b want %b %b 1", i, cpu_if.gnt, dbg_if.gnt, mem_e, ~dbg_pat[i], dbg_pat[i]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_lock();
    logic [5:0] lock_pat, dreq_pat, dbg_pat;
    owner_t     exp_own [6];
    dbg_pat = 6'b010000;
`ifdef DMEM_ARB_RR_EN
    lock_pat = 6'b000111;
    dreq_pat = 6'b111110;
    exp_own  = '{OWN_IDLE, OWN_CPU, OWN_CPU, OWN_CPU, OWN_IDLE, OWN_IDLE};
`else
    lock_pat = 6'b111111;
    dreq_pat = 6'b111111;
    exp_own  = '{OWN_IDLE, OWN_CPU, OWN_CPU, OWN_CPU, OWN_CPU, OWN_IDLE};
`endif
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive_cpu(1, 0, lock_pat[i], 4'd7, 8'h00);
      drive_dbg(dreq_pat[i], 0, 0, 4'd8, 8'h00);
      @(negedge clk);
      n_checks++;
      if (cpu_if.gnt !== ~dbg_pat[i] || dbg_if.gnt !== dbg_pat[i] || owner !== exp_own[i]) begin
        n_fail++;
        $display("FAIL lock[%0d]: got cpu=%b dbg=%b own=%0d want %b %b %0d", i, cpu_if.gnt, dbg_if.gnt, owner, ~dbg_pat[i], dbg_pat[i], exp_own[i]);
      end
    end
    idle_cycle();
  endtask

  task automatic test_lock_drop();
    @(posedge clk); #1;
    drive_dbg(1, 0, 1, 4'd4, 8'h00);
    @(negedge clk);
    n_checks++; if (dbg_if.gnt !== 1'b1 || owner !== OWN_IDLE) begin n_fail++; $display("FAIL drop_take: got gnt=%b own=%0d want 1 0", dbg_if.gnt, owner); end
    @(posedge clk); #1;
    drive_cpu(1, 0, 0, 4'd6, 8'h00);
    @(negedge clk);
    n_checks++; if (dbg_if.gnt !== 1'b1 || cpu_if.gnt !== 1'b0 || owner !== OWN_DBG) begin n_fail++; $display("FAIL drop_owned: got dbg=%b cpu=%b own=%0d want 1 0 2", dbg_if.gnt, cpu_if.gnt, owner); end
    @(posedge clk); #1;
    drive_dbg(0, 0, 0, 4'd0, 8'h00);
    @(negedge clk);
    n_checks++; if (cpu_if.gnt !== 1'b1 || dbg_if.gnt !== 1'b0) begin n_fail++; $display("FAIL drop_cpu_gnt: got cpu=%b dbg=%b want 1 0", cpu_if.gnt, dbg_if.gnt); end
    @(posedge clk); #1;
    drive_cpu(0, 0, 0, 4'd0, 8'h00);
    @(negedge clk);
    n_checks++; if (owner !== OWN_IDLE) begin n_fail++; $display("FAIL drop_owner: got %0d want 0", owner); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_reset_mid_read();
    test_back_to_back();
    idle_cycle();
    test_contention();
    test_lock();
    test_lock_drop();
    idle_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
